// File: rtl/gol_pkg.sv
// rtl/gol_pkg.sv - shared types and screen constants for the Game of Life display path
package gol_pkg;

    typedef logic [2:0] colour_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        PLOT,
        ADVANCE,
        DONE
    } render_state_t;

    // Counter width for n distinct values, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/board_renderer_if.sv
// rtl/board_renderer_if.sv - control, board RAM and VGA plot signals of the renderer
interface board_renderer_if #(
    parameter int ADDR_W = 12
);
    import gol_pkg::*;

    logic              start;
    logic              live_only;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rdata;
    logic [7:0]        vga_x;
    logic [6:0]        vga_y;
    colour_t           vga_colour;
    logic              vga_plot;

    modport master (
        input  start, live_only, mem_rdata,
        output busy, done, mem_addr, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        output start, live_only, mem_rdata,
        input  busy, done, mem_addr, vga_x, vga_y, vga_colour, vga_plot
    );

endinterface

// File: rtl/cell_scan_counter.sv
// rtl/cell_scan_counter.sv - 2-D row-major wrap counter, x fastest
module cell_scan_counter
    import gol_pkg::*;
#(
    parameter int X_N = 2,
    parameter int Y_N = 2,
    parameter int XW  = idx_width(X_N),
    parameter int YW  = idx_width(Y_N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    logic x_last;
    logic y_last;

    assign x_last = (x == XW'(X_N - 1));
    assign y_last = (y == YW'(Y_N - 1));
    assign last   = x_last && y_last;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            x <= '0;
            y <= '0;
        end else if (inc) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/board_renderer.sv
// rtl/board_renderer.sv - scans the board RAM once per frame and emits VGA plot requests
module board_renderer
    import gol_pkg::*;
#(
    parameter int      X_CELLS     = 50,
    parameter int      Y_CELLS     = 50,
    parameter int      CELL_PX     = 1,
    parameter int      X_ORIGIN    = 0,
    parameter int      Y_ORIGIN    = 0,
    parameter colour_t LIVE_COLOUR = 3'b111,
    parameter colour_t DEAD_COLOUR = 3'b000
) (
    input  logic              clk,
    input  logic              rst,
    board_renderer_if.master  bus
);

    localparam int XW     = idx_width(X_CELLS);
    localparam int YW     = idx_width(Y_CELLS);
    localparam int PW     = idx_width(CELL_PX);
    localparam int ADDR_W = $clog2(X_CELLS * Y_CELLS);

    if (CELL_PX < 1 || CELL_PX > 4) begin : g_bad_cell_px
        $error("board_renderer: CELL_PX must be in 1..4");
    end
    if (X_ORIGIN < 0 || X_ORIGIN + X_CELLS * CELL_PX > SCREEN_W) begin : g_bad_x
        $error("board_renderer: board does not fit horizontally");
    end
    if (Y_ORIGIN < 0 || Y_ORIGIN + Y_CELLS * CELL_PX > SCREEN_H) begin : g_bad_y
        $error("board_renderer: board does not fit vertically");
    end

    render_state_t state;
    logic          live_only_q;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic [PW-1:0] px;
    logic [PW-1:0] py;
    logic          cell_last;
    logic          pix_last;
    logic          px_wrap;
    logic [7:0]    base_x;
    logic [7:0]    nxt_x;
    logic [6:0]    base_y;
    logic [6:0]    nxt_y;

    cell_scan_counter #(.X_N(X_CELLS), .Y_N(Y_CELLS)) u_cell_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (state == IDLE && bus.start),
        .inc   (state == ADVANCE),
        .x     (cx),
        .y     (cy),
        .last  (cell_last)
    );

    cell_scan_counter #(.X_N(CELL_PX), .Y_N(CELL_PX)) u_pix_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (state == WAIT),
        .inc   (state == PLOT),
        .x     (px),
        .y     (py),
        .last  (pix_last)
    );

    assign bus.mem_addr = ADDR_W'(int'(cy) * X_CELLS + int'(cx));

    // Coordinates of the pixel that follows (px, py) inside the current cell
    always_comb begin
        base_x  = 8'(X_ORIGIN + int'(cx) * CELL_PX);
        base_y  = 7'(Y_ORIGIN + int'(cy) * CELL_PX);
        px_wrap = (px == PW'(CELL_PX - 1));
        nxt_x   = px_wrap ? base_x : base_x + 8'(px) + 8'd1;
        nxt_y   = px_wrap ? base_y + 7'(py) + 7'd1 : base_y + 7'(py);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            live_only_q    <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.vga_plot   <= 1'b0;
            bus.vga_x      <= '0;
            bus.vga_y      <= '0;
            bus.vga_colour <= '0;
        end else begin
            bus.done     <= 1'b0;
            bus.vga_plot <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state       <= FETCH;
                        bus.busy    <= 1'b1;
                        live_only_q <= bus.live_only;
                    end
                end
                FETCH: state <= WAIT;
                WAIT: begin
                    if (bus.mem_rdata || !live_only_q) begin
                        state          <= PLOT;
                        bus.vga_plot   <= 1'b1;
                        bus.vga_x      <= base_x;
                        bus.vga_y      <= base_y;
                        bus.vga_colour <= bus.mem_rdata ? LIVE_COLOUR : DEAD_COLOUR;
                    end else begin
                        state <= ADVANCE;
                    end
                end
                PLOT: begin
                    if (pix_last) begin
                        state <= ADVANCE;
                    end else begin
                        bus.vga_plot <= 1'b1;
                        bus.vga_x    <= nxt_x;
                        bus.vga_y    <= nxt_y;
                    end
                end
                ADVANCE: begin
                    if (cell_last) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else begin
                        state <= FETCH;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_renderer.sv
// tb/tb_board_renderer.sv - directed bench for board_renderer
module tb_board_renderer;
    import gol_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int pcount = 0;
    always @(posedge clk) pcount++;

    board_renderer_if #(.ADDR_W(12)) bus_a ();
    board_renderer_if #(.ADDR_W(12)) bus_b ();

    board_renderer dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    board_renderer #(.CELL_PX(2), .X_ORIGIN(10), .Y_ORIGIN(5)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    bit board [0:2499];
    always @(posedge clk) bus_a.mem_rdata <= board[bus_a.mem_addr];
    always @(posedge clk) bus_b.mem_rdata <= (bus_b.mem_addr == 12'd103);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Frame monitor for dut_a, restarted by every accepted start
    int t0_a, plots_a, first_cyc_a, first_x_a, first_y_a, last_x_a, last_y_a;
    int order_err_a, col_err_a, live_plots_a, done_n_a, done_cyc_a;
    int addr_chg_a, addr_bad_a, prev_addr_a;
    always @(negedge clk) begin
        if (!rst && bus_a.start && !bus_a.busy) begin
            t0_a = pcount; plots_a = 0; first_cyc_a = -1; order_err_a = 0;
            col_err_a = 0; live_plots_a = 0; done_n_a = 0; done_cyc_a = -1;
            addr_chg_a = 0; addr_bad_a = 0; prev_addr_a = 0;
        end
        if (bus_a.vga_plot) begin
            if (plots_a == 0) begin
                first_cyc_a = pcount - t0_a;
                first_x_a = int'(bus_a.vga_x);
                first_y_a = int'(bus_a.vga_y);
            end
            if (int'(bus_a.vga_x) != plots_a % 50 || int'(bus_a.vga_y) != plots_a / 50)
                order_err_a++;
            if (plots_a < 2500 && bus_a.vga_colour != (board[plots_a] ? 3'b111 : 3'b000))
                col_err_a++;
            if (bus_a.vga_colour != 3'b000) live_plots_a++;
            last_x_a = int'(bus_a.vga_x);
            last_y_a = int'(bus_a.vga_y);
            plots_a++;
        end
        if (bus_a.done) begin
            done_n_a++;
            done_cyc_a = pcount - t0_a;
        end
        if (bus_a.busy && !bus_a.done && int'(bus_a.mem_addr) != prev_addr_a) begin
            addr_chg_a++;
            if (int'(bus_a.mem_addr) != prev_addr_a + 1) addr_bad_a++;
            prev_addr_a = int'(bus_a.mem_addr);
        end
    end

    int t0_b, nb, done_n_b, done_cyc_b;
    int bx [4];
    int by [4];
    int bc [4];
    int bcyc [4];
    always @(negedge clk) begin
        if (!rst && bus_b.start && !bus_b.busy) begin
            t0_b = pcount; nb = 0; done_n_b = 0; done_cyc_b = -1;
        end
        if (bus_b.vga_plot) begin
            if (nb < 4) begin
                bx[nb] = int'(bus_b.vga_x);
                by[nb] = int'(bus_b.vga_y);
                bc[nb] = int'(bus_b.vga_colour);
                bcyc[nb] = pcount - t0_b;
            end
            nb++;
        end
        if (bus_b.done) begin
            done_n_b++;
            done_cyc_b = pcount - t0_b;
        end
    end

    task automatic pulse_start_a(input logic lo);
        @(posedge clk); #1;
        bus_a.live_only = lo;
        bus_a.start = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        for (int i = 0; i < 20000 && done_n_a == 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_seen"}, (done_n_a > 0) ? 1 : 0, 1);
    endtask

    int exp_bx [4] = '{16, 17, 16, 17};
    int exp_by [4] = '{9, 9, 10, 10};

    initial begin
        bus_a.start = 1'b0; bus_a.live_only = 1'b0;
        bus_b.start = 1'b0; bus_b.live_only = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(bus_a.busy), 0);
        chk("rst_done", int'(bus_a.done), 0);
        chk("rst_plot", int'(bus_a.vga_plot), 0);
        chk("rst_x", int'(bus_a.vga_x), 0);
        chk("rst_y", int'(bus_a.vga_y), 0);
        chk("rst_colour", int'(bus_a.vga_colour), 0);
        chk("rst_addr", int'(bus_a.mem_addr), 0);
        rst = 1'b0;

        // All dead, every cell plotted
        pulse_start_a(1'b0);
        chk("dead_busy", int'(bus_a.busy), 1);
        wait_done_a("dead_all");
        chk("dead_all_plots", plots_a, 2500);
        chk("dead_all_live", live_plots_a, 0);
        chk("dead_all_first_cyc", first_cyc_a, 3);
        chk("dead_all_first_x", first_x_a, 0);
        chk("dead_all_first_y", first_y_a, 0);
        chk("dead_all_last_x", last_x_a, 49);
        chk("dead_all_last_y", last_y_a, 49);
        chk("dead_all_order", order_err_a, 0);
        chk("dead_all_done_cyc", done_cyc_a, 10001);
        chk("dead_all_done_n", done_n_a, 1);
        chk("dead_all_addr_chg", addr_chg_a, 2499);
        chk("dead_all_addr_bad", addr_bad_a, 0);
        chk("dead_all_idle", int'(bus_a.busy), 0);
        chk("dead_all_hold_x", int'(bus_a.vga_x), 49);

        // All dead, live cells only
        pulse_start_a(1'b1);
        wait_done_a("dead_live");
        chk("dead_live_plots", plots_a, 0);
        chk("dead_live_done_cyc", done_cyc_a, 7501);

        // Glider
        board[1] = 1'b1; board[52] = 1'b1; board[100] = 1'b1;
        board[101] = 1'b1; board[102] = 1'b1;
        pulse_start_a(1'b0);
        wait_done_a("glider");
        chk("glider_plots", plots_a, 2500);
        chk("glider_order", order_err_a, 0);
        chk("glider_colour", col_err_a, 0);
        chk("glider_live", live_plots_a, 5);
        chk("glider_addr_chg", addr_chg_a, 2499);
        chk("glider_addr_bad", addr_bad_a, 0);

        // Second start mid-frame is ignored
        pulse_start_a(1'b0);
        repeat (499) @(posedge clk);
        #1;
        bus_a.start = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        wait_done_a("retrig");
        chk("retrig_done_cyc", done_cyc_a, 10001);
        chk("retrig_done_n", done_n_a, 1);
        chk("retrig_plots", plots_a, 2500);

        // Reset at frame cycle 4000
        pulse_start_a(1'b0);
        repeat (3999) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", int'(bus_a.busy), 0);
        chk("midrst_plot", int'(bus_a.vga_plot), 0);
        chk("midrst_x", int'(bus_a.vga_x), 0);
        chk("midrst_y", int'(bus_a.vga_y), 0);
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_no_done", done_n_a, 0);
        chk("midrst_plots", plots_a, 1000);

        // start coincident with rst is dropped
        bus_a.start = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_start_busy", int'(bus_a.busy), 0);

        pulse_start_a(1'b0);
        wait_done_a("after_rst");
        chk("after_rst_done_cyc", done_cyc_a, 10001);
        chk("after_rst_first_cyc", first_cyc_a, 3);
        chk("after_rst_plots", plots_a, 2500);

        // Second instance: CELL_PX=2, origin (10,5), live cell (3,2)
        @(posedge clk); #1;
        bus_b.live_only = 1'b1;
        bus_b.start = 1'b1;
        @(posedge clk); #1;
        bus_b.start = 1'b0;
        for (int i = 0; i < 20000 && done_n_b == 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("cell2_plots", nb, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cell2_x%0d", i), bx[i], exp_bx[i]);
            chk($sformatf("cell2_y%0d", i), by[i], exp_by[i]);
            chk($sformatf("cell2_c%0d", i), bc[i], 7);
        end
        chk("cell2_first_cyc", bcyc[0], 312);
        chk("cell2_last_cyc", bcyc[3], 315);
        chk("cell2_done_cyc", done_cyc_b, 7505);
        chk("cell2_done_n", done_n_b, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
